// File: rtl/prf_free_list_pkg.sv
// prf_free_list_pkg: shared PRF sizing constants and bitmap helpers
package prf_free_list_pkg;
    localparam int PRF_size  = 64;
    localparam int PRF_width = $clog2(PRF_size);
    localparam int ARCH_regs = 32;

    localparam logic [PRF_size-1:0] RESET_LIST  = {{(PRF_size-ARCH_regs){1'b1}}, {ARCH_regs{1'b0}}};
    localparam logic [PRF_width:0]  RESET_COUNT = (PRF_width+1)'(PRF_size-ARCH_regs);

    function automatic logic [PRF_width:0] popcount(input logic [PRF_size-1:0] v);
        popcount = '0;
        for (int i = 0; i < PRF_size; i++) popcount += (PRF_width+1)'(v[i]);
    endfunction

    function automatic logic [PRF_size-1:0] onehot(input logic [PRF_width-1:0] idx);
        onehot = {{(PRF_size-1){1'b0}}, 1'b1} << idx;
    endfunction
endpackage

// File: rtl/prf_free_list_if.sv
// prf_free_list_if: allocation, retire and recovery signals between RAT/ROB/RRAT and the free list
interface prf_free_list_if;
    import prf_free_list_pkg::*;
    logic                 RAT_alloc_req_in;
    logic                 ROB_retire_in;
    logic [PRF_width-1:0] ROB_retire_old_idx_in;
    logic                 ROB_mispredict_in;
    logic [PRF_size-1:0]  RRAT_PRF_FL_in;
    logic [PRF_width-1:0] free_idx_out;
    logic                 free_valid_out;
    logic                 alloc_grant_out;
    logic [PRF_width:0]   free_count_out;
    logic [PRF_size-1:0]  free_list_out;

    modport master (
        output RAT_alloc_req_in, ROB_retire_in, ROB_retire_old_idx_in, ROB_mispredict_in, RRAT_PRF_FL_in,
        input  free_idx_out, free_valid_out, alloc_grant_out, free_count_out, free_list_out
    );
    modport slave (
        input  RAT_alloc_req_in, ROB_retire_in, ROB_retire_old_idx_in, ROB_mispredict_in, RRAT_PRF_FL_in,
        output free_idx_out, free_valid_out, alloc_grant_out, free_count_out, free_list_out
    );
endinterface

// File: rtl/prf_fl_penc.sv
// prf_fl_penc: lowest-index priority encoder; idx is 0 when nothing is set
module prf_fl_penc #(
    parameter int N = 64,
    parameter int W = 6
) (
    input  logic [N-1:0] req,
    output logic [W-1:0] idx,
    output logic         valid
);
    // scan downward so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = N-1; i >= 0; i--) if (req[i]) idx = W'(i);
    end
    assign valid = |req;
endmodule

// File: rtl/prf_free_list.sv
// prf_free_list: bitmap of free physical registers, lowest-index allocation, RRAT recovery
module prf_free_list
    import prf_free_list_pkg::*;
(
    input logic            clock,
    input logic            reset,
    prf_free_list_if.slave bus
);
    logic [PRF_size-1:0]  free_list, next_list, ret_mask, grant_mask;
    logic [PRF_width:0]   free_count, next_count;
    logic [PRF_width-1:0] free_idx;
    logic                 free_valid, grant, ret_new;

    prf_fl_penc #(.N(PRF_size), .W(PRF_width)) penc (.req(free_list), .idx(free_idx), .valid(free_valid));

    // next bitmap and count; a retire of an already-free index adds nothing to the count
    always_comb begin
        grant      = bus.RAT_alloc_req_in & free_valid & ~bus.ROB_mispredict_in;
        ret_mask   = bus.ROB_retire_in ? onehot(bus.ROB_retire_old_idx_in) : '0;
        grant_mask = grant ? onehot(free_idx) : '0;
        ret_new    = bus.ROB_retire_in & ~free_list[bus.ROB_retire_old_idx_in];
        next_list  = bus.ROB_mispredict_in ? (bus.RRAT_PRF_FL_in | ret_mask) : ((free_list & ~grant_mask) | ret_mask);
        next_count = bus.ROB_mispredict_in ? popcount(next_list)
                   : free_count + (PRF_width+1)'(ret_new) - (PRF_width+1)'(grant);
    end

    // state register; reset marks the architectural mappings busy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            free_list  <= RESET_LIST;
            free_count <= RESET_COUNT;
        end else begin
            free_list  <= next_list;
            free_count <= next_count;
        end
    end

    assign bus.free_idx_out    = free_idx;
    assign bus.free_valid_out  = free_valid;
    assign bus.alloc_grant_out = grant;
    assign bus.free_count_out  = free_count;
    assign bus.free_list_out   = free_list;

    retire_of_free_idx: assert property (@(posedge clock) disable iff (reset)
        !(bus.ROB_retire_in && !bus.ROB_mispredict_in && free_list[bus.ROB_retire_old_idx_in]));
endmodule
